// File: rtl/fp_pkg.sv
// Shared widths and field positions for the binary32 add/subtract datapath.
// The internal fraction layout is {carry, hidden, fraction[22:0], guard, sticky}.
package fp_pkg;
    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int INT_FRAC_W = 27;
    localparam int WORD_W     = 1 + EXP_W + FRAC_W;

    localparam int SIGN_BIT  = WORD_W - 1;
    localparam int EXP_MSB   = WORD_W - 2;
    localparam int EXP_LSB   = FRAC_W;

    localparam int CARRY_BIT  = INT_FRAC_W - 1;
    localparam int HIDDEN_BIT = INT_FRAC_W - 2;
    localparam int LSB_BIT    = 2;
    localparam int GUARD_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam int SHIFT_DIR_BIT = 8;
    localparam int INC_DEC_BIT   = 8;

    // Denormals are not handled, so the hidden bit is forced to 1.
    function automatic logic [INT_FRAC_W-1:0] to_int_frac(input logic [FRAC_W-1:0] frac);
        return {1'b0, 1'b1, frac, 2'b00};
    endfunction
endpackage

// File: rtl/fp_shift_sticky.sv
// Right/left shifter; on a right shift every bit pushed out at or below bit 0
// is ORed into bit 0 so the sticky information survives alignment and normalization.
module fp_shift_sticky #(
    parameter int W   = 27,
    parameter int SHW = 8
) (
    input  logic [W-1:0]   data_i,
    input  logic [SHW-1:0] amt_i,
    input  logic           right_i,
    output logic [W-1:0]   data_o
);
    logic [W-1:0] below_mask;
    logic [W-1:0] right_val;
    logic [W-1:0] left_val;
    logic         lost;

    // below_mask marks the bit positions a right shift of amt_i discards.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign below_mask[gi] = (32'(gi) < 32'(amt_i));
        end
    endgenerate

    assign lost      = |(data_i & below_mask);
    assign right_val = (data_i >> amt_i) | W'(lost);
    assign left_val  = data_i << amt_i;
    assign data_o    = right_i ? right_val : left_val;
endmodule

// File: rtl/fp_add_fd.sv
// Binary32 add/subtract datapath steered entirely by an external control FSM;
// exposes exp_dif/ula as status and registers the rounded fraction and result word.
module fp_add_fd
    import fp_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     operando_a,
    input  logic [WORD_W-1:0]     operando_b,
    input  logic                  sinalMuxFP1,
    input  logic                  sinalMuxFP2,
    input  logic                  sinalMuxFP3,
    input  logic                  sinalMuxFP4,
    input  logic                  sinalMuxFP5,
    input  logic [7:0]            sinalShiftFract,
    input  logic [8:0]            sinalShiftRes,
    input  logic [8:0]            sinalIncOrDec,
    input  logic                  sinalRound,
    output logic [EXP_W-1:0]      exp_dif,
    output logic [INT_FRAC_W-1:0] ula,
    output logic [INT_FRAC_W-1:0] round_fract,
    output logic [WORD_W-1:0]     resultado
);
    logic [EXP_W-1:0]      exp_a, exp_b, exp_base, exp_adj;
    logic [INT_FRAC_W-1:0] frac_a, frac_b;
    logic [INT_FRAC_W-1:0] align_in, aligned, unshifted;
    logic [INT_FRAC_W-1:0] norm_in, normalized, rounded_sum, rounded;
    logic                  round_inc, sign_sel;

    logic [INT_FRAC_W-1:0] round_fract_q, round_fract_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    logic [WORD_W-1:0]     resultado_q, resultado_d;

    assign exp_a  = operando_a[EXP_MSB:EXP_LSB];
    assign exp_b  = operando_b[EXP_MSB:EXP_LSB];
    assign frac_a = to_int_frac(operando_a[FRAC_W-1:0]);
    assign frac_b = to_int_frac(operando_b[FRAC_W-1:0]);

    assign exp_dif = exp_a - exp_b;

    assign align_in  = sinalMuxFP2 ? frac_a : frac_b;
    assign unshifted = sinalMuxFP3 ? frac_a : frac_b;

    fp_shift_sticky #(.W(INT_FRAC_W), .SHW(8)) u_align (
        .data_i  (align_in),
        .amt_i   (sinalShiftFract),
        .right_i (1'b1),
        .data_o  (aligned)
    );

    assign ula = sinalMuxFP5 ? (unshifted - aligned) : (unshifted + aligned);

    // FP4 closes the renormalization loop through the registered fraction.
    assign norm_in = sinalMuxFP4 ? round_fract_q : ula;

    fp_shift_sticky #(.W(INT_FRAC_W), .SHW(8)) u_norm (
        .data_i  (norm_in),
        .amt_i   (sinalShiftRes[7:0]),
        .right_i (sinalShiftRes[SHIFT_DIR_BIT]),
        .data_o  (normalized)
    );

    assign round_inc = sinalRound & normalized[GUARD_BIT]
                     & (normalized[STICKY_BIT] | normalized[LSB_BIT]);
    assign rounded_sum = normalized + INT_FRAC_W'({round_inc, 2'b00});
    assign rounded     = {rounded_sum[INT_FRAC_W-1:LSB_BIT], 2'b00};

    assign exp_base = sinalMuxFP1 ? exp_q : (sinalMuxFP3 ? exp_a : exp_b);
    assign exp_adj  = sinalIncOrDec[INC_DEC_BIT] ? (exp_base - sinalIncOrDec[7:0])
                                                 : (exp_base + sinalIncOrDec[7:0]);

    assign sign_sel = sinalMuxFP3 ? operando_a[SIGN_BIT] : operando_b[SIGN_BIT];

    always_comb begin
        round_fract_d = rounded;
        exp_d         = exp_adj;
        resultado_d   = {sign_sel, exp_adj, rounded[HIDDEN_BIT-1:LSB_BIT]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            round_fract_q <= '0;
            exp_q         <= '0;
            resultado_q   <= '0;
        end else begin
            round_fract_q <= round_fract_d;
            exp_q         <= exp_d;
            resultado_q   <= resultado_d;
        end
    end

    assign round_fract = round_fract_q;
    assign resultado   = resultado_q;

    // The carry bit is only observed by the FSM through round_fract.
    logic unused_carry;
    assign unused_carry = rounded[CARRY_BIT];
endmodule

// File: tb/tb_fp_add_fd.sv
// Self-checking bench for fp_add_fd: an arithmetic reference model checked every
// cycle under random steering, plus literal expectations for hand-worked cases.
module tb_fp_add_fd;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] operando_a = '0, operando_b = '0;
    logic        sinalMuxFP1 = 0, sinalMuxFP2 = 0, sinalMuxFP3 = 0, sinalMuxFP4 = 0, sinalMuxFP5 = 0;
    logic [7:0]  sinalShiftFract = '0;
    logic [8:0]  sinalShiftRes = '0, sinalIncOrDec = '0;
    logic        sinalRound = 0;
    logic [7:0]  exp_dif;
    logic [26:0] ula, round_fract;
    logic [31:0] resultado;

    int n_vec = 0;
    int n_err = 0;

    fp_add_fd dut (
        .clock(clock), .reset(reset),
        .operando_a(operando_a), .operando_b(operando_b),
        .sinalMuxFP1(sinalMuxFP1), .sinalMuxFP2(sinalMuxFP2), .sinalMuxFP3(sinalMuxFP3),
        .sinalMuxFP4(sinalMuxFP4), .sinalMuxFP5(sinalMuxFP5),
        .sinalShiftFract(sinalShiftFract), .sinalShiftRes(sinalShiftRes),
        .sinalIncOrDec(sinalIncOrDec), .sinalRound(sinalRound),
        .exp_dif(exp_dif), .ula(ula), .round_fract(round_fract), .resultado(resultado)
    );

    always #5 clock = ~clock;

    localparam longint MASK27 = (64'd1 << 27) - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Model: value of the mantissa with hidden bit, scaled by 4 for guard/sticky.
    function automatic longint mant(input logic [31:0] w);
        return ((64'd1 << 23) + longint'(w[22:0])) * 4;
    endfunction

    // Divide by 2^sh keeping a sticky "anything lost" flag in the lowest bit.
    function automatic longint div_sticky(input longint x, input int sh);
        longint q, r;
        if (sh >= 27) return (x != 0) ? 1 : 0;
        q = x / (64'd1 << sh);
        r = x % (64'd1 << sh);
        if (r != 0 && (q % 2) == 0) q = q + 1;
        return q;
    endfunction

    // Model registers: the values the DUT must hold after the last edge.
    longint m_rf = 0;
    int     m_exp = 0;
    longint m_res = 0;
    bit     m_valid = 0;

    always @(negedge clock) begin : compare
        longint ua, ub, al, un, ul, ni, nv, rv, r_next;
        int ea, eb, base, adj, sh;
        bit sg;
        ea = int'(operando_a[30:23]);
        eb = int'(operando_b[30:23]);
        ua = mant(operando_a);
        ub = mant(operando_b);
        al = div_sticky(sinalMuxFP2 ? ua : ub, int'(sinalShiftFract));
        un = sinalMuxFP3 ? ua : ub;
        ul = sinalMuxFP5 ? (un - al) : (un + al);
        ul = ul & MASK27;
        check("exp_dif", 32'(exp_dif), 32'((ea - eb) & 255));
        check("ula", 32'(ula), 32'(ul));
        if (m_valid) begin
            check("round_fract", 32'(round_fract), 32'(m_rf));
            check("resultado", resultado, 32'(m_res));
        end
        ni = sinalMuxFP4 ? m_rf : ul;
        sh = int'(sinalShiftRes[7:0]);
        if (sinalShiftRes[8]) nv = div_sticky(ni, sh);
        else nv = (sh >= 27) ? 0 : ((ni * (64'd1 << sh)) & MASK27);
        rv = nv;
        if (sinalRound && ((nv / 2) % 2 == 1) && ((nv % 2 == 1) || ((nv / 4) % 2 == 1)))
            rv = nv + 4;
        rv = (rv & MASK27) / 4 * 4;
        base = sinalMuxFP1 ? m_exp : (sinalMuxFP3 ? ea : eb);
        adj = sinalIncOrDec[8] ? (base - int'(sinalIncOrDec[7:0])) : (base + int'(sinalIncOrDec[7:0]));
        adj = adj & 255;
        sg = sinalMuxFP3 ? operando_a[31] : operando_b[31];
        r_next = (longint'(sg) << 31) + (longint'(adj) << 23) + ((rv / 4) % (64'd1 << 23));
        if (reset) begin
            m_rf = 0; m_exp = 0; m_res = 0; m_valid = 1;
        end else if (m_valid) begin
            m_rf = rv; m_exp = adj; m_res = r_next;
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic f1, input logic f2, input logic f3, input logic f4, input logic f5,
                         input logic [7:0] sf, input logic [8:0] sr, input logic [8:0] id, input logic rnd);
        operando_a = a; operando_b = b;
        sinalMuxFP1 = f1; sinalMuxFP2 = f2; sinalMuxFP3 = f3; sinalMuxFP4 = f4; sinalMuxFP5 = f5;
        sinalShiftFract = sf; sinalShiftRes = sr; sinalIncOrDec = id; sinalRound = rnd;
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        next_edge();
        check("reset_resultado", resultado, 32'h0);
        check("reset_round_fract", 32'(round_fract), 32'h0);
        reset = 1'b0;

        // 1.5 + 0.5 with carry, right-normalized by one
        drive(32'h3FC00000, 32'h3F000000, 0, 0, 1, 0, 0, 8'd1, 9'h101, 9'h001, 0);
        @(negedge clock); #1;
        check("add_exp_dif", 32'(exp_dif), 32'h01);
        check("add_ula_carry", 32'(ula[26]), 32'h1);
        next_edge();
        check("add_result", resultado, 32'h40000000);

        drive(32'h3FA24DD3, 32'h401D2F1B, 0, 1, 0, 0, 0, 8'd1, 9'h100, 9'h000, 1);
        @(negedge clock); #1;
        check("tie_exp_dif", 32'(exp_dif), 32'hFF);
        next_edge();
        check("tie_even_rnd", resultado, 32'h406E5604);
        sinalRound = 0;
        next_edge();
        check("tie_even_trunc", resultado, 32'h406E5604);

        drive(32'h3FC00000, 32'h3F000000, 0, 0, 1, 0, 1, 8'd1, 9'h100, 9'h000, 0);
        next_edge();
        check("sub_result", resultado, 32'h3F800000);

        drive(32'h3F800001, 32'h33800000, 0, 0, 1, 0, 0, 8'd24, 9'h100, 9'h000, 1);
        next_edge();
        check("round_up", resultado, 32'h3F800002);
        sinalRound = 0;
        next_edge();
        check("round_trunc", resultado, 32'h3F800001);

        drive(32'h3F800001, 32'h32000000, 0, 0, 1, 0, 0, 8'd27, 9'h100, 9'h000, 1);
        @(negedge clock); #1;
        check("sticky_ula0", 32'(ula[0]), 32'h1);
        check("sticky_ula1", 32'(ula[1]), 32'h0);
        next_edge();
        check("sticky_rnd", resultado, 32'h3F800001);
        sinalRound = 0;
        next_edge();
        check("sticky_trunc", resultado, 32'h3F800001);

        // Rounding overflow into the carry, then one renormalization pass
        drive(32'h3FFFFFFF, 32'h33800000, 0, 0, 1, 0, 0, 8'd24, 9'h100, 9'h000, 1);
        next_edge();
        check("ovf_round_fract", 32'(round_fract), 32'h4000000);
        drive(32'h3FFFFFFF, 32'h33800000, 1, 0, 1, 1, 0, 8'd24, 9'h101, 9'h001, 1);
        next_edge();
        check("renorm_result", resultado, 32'h40000000);

        for (int i = 0; i < 400; i++) begin
            drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 8'($urandom_range(0, 30)),
                  {1'($urandom), 8'($urandom_range(0, 30))},
                  {1'($urandom), 8'($urandom_range(0, 40))}, 1'($urandom));
            reset = ($urandom_range(0, 49) == 0);
            next_edge();
        end
        reset = 1'b0;
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
